// File: rtl/ram_pkg.sv
// Shared types for the simple-dual-port RAM controller.
// Holds the clear FSM encoding and the read-during-write mode selectors.
package ram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  // Replace only the enabled bytes of old_w with new_w.
  function automatic logic [63:0] be_merge64(
    input logic [63:0] old_w,
    input logic [63:0] new_w,
    input logic [7:0]  be
  );
    logic [63:0] r;
    r = old_w;
    for (int i = 0; i < 8; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks every address once after reset or on request.
// While it runs the RAM is owned by this block and user traffic is dropped.
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr_req,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr,
  output logic              o_busy
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              w_last;

  assign w_last = &r_cnt;

  // The counter wraps to 0 on the exit edge, so a new clear starts clean.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= CLEAR;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_last) r_state <= IDLE;
        end
        IDLE: begin
          if (i_clr_req) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
          end
        end
        default: begin
          r_state <= CLEAR;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_busy     = (r_state == CLEAR);
  assign o_clr_we   = o_busy;
  assign o_clr_addr = r_cnt;

endmodule

// File: rtl/sdp_ram_ctrl.sv
// Simple-dual-port RAM with byte enables, collision bypass, optional
// output register and a self-clearing array.
module sdp_ram_ctrl
  import ram_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int OUT_REG = 0,
  parameter int RD_MODE = 0
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                clr_req,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                init_busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  if ((DATA_W % 8) != 0) begin : g_bad_width
    $error("sdp_ram_ctrl: DATA_W must be a multiple of 8");
  end

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_busy;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_usr_wr;
  logic              w_usr_rd;
  logic              w_usr_clr;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [BE_W-1:0]   w_wbe;
  logic              w_hit;
  logic [DATA_W-1:0] w_rword;
  logic [DATA_W-1:0] w_merged;
  logic [DATA_W-1:0] w_rnext;

  logic [DATA_W-1:0] r_d1;
  logic              r_v1;

  assign w_usr_wr  = wr_en & ~w_busy;
  assign w_usr_rd  = rd_en & ~w_busy;
  assign w_usr_clr = clr_req & ~w_busy;

  ram_clear_seq #(
    .ADDR_W (ADDR_W)
  ) u_clr (
    .i_clk      (sys_clk),
    .i_rst      (sys_rst),
    .i_clr_req  (w_usr_clr),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr),
    .o_busy     (w_busy)
  );

  assign w_we    = w_clr_we | w_usr_wr;
  assign w_waddr = w_clr_we ? w_clr_addr : wr_addr;
  assign w_wdata = w_clr_we ? '0 : wr_data;
  assign w_wbe   = w_clr_we ? {BE_W{1'b1}} : wr_be;

  always_ff @(posedge sys_clk) begin
    if (w_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (w_wbe[i]) r_mem[w_waddr][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

  assign w_rword = r_mem[rd_addr];
  assign w_hit   = w_usr_wr & (wr_addr == rd_addr);

  always_comb begin
    w_merged = w_rword;
    for (int i = 0; i < BE_W; i++) begin
      if (wr_be[i]) w_merged[8*i +: 8] = wr_data[8*i +: 8];
    end
  end

  // Write-first forwards the merged word; read-first sees the array as-is.
  assign w_rnext = ((RD_MODE == WR_FIRST) && w_hit) ? w_merged : w_rword;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_d1 <= '0;
      r_v1 <= 1'b0;
    end else begin
      r_v1 <= w_usr_rd;
      if (w_usr_rd) r_d1 <= w_rnext;
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [DATA_W-1:0] r_d2;
    logic              r_v2;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
        r_d2 <= '0;
        r_v2 <= 1'b0;
      end else begin
        r_v2 <= r_v1;
        if (r_v1) r_d2 <= r_d1;
      end
    end

    assign rd_data  = r_d2;
    assign rd_valid = r_v2;
  end else begin : g_noreg
    assign rd_data  = r_d1;
    assign rd_valid = r_v1;
  end

  assign init_busy = w_busy;

endmodule

// File: tb/tb_sdp_ram_ctrl.sv
// Scoreboard bench driving a read-first/latency-1 and a write-first/latency-2
// instance with identical stimulus.
module tb_sdp_ram_ctrl;

  logic        clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        clr_req = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_be = '0;
  logic        rd_en = 1'b0;
  logic [7:0]  rd_addr = '0;

  logic [31:0] rd_data0, rd_data1;
  logic        rd_valid0, rd_valid1;
  logic        busy0, busy1;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] d;
    int          c;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic [31:0] m_mem [256];

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdp_ram_ctrl #(.DATA_W(32), .ADDR_W(8), .OUT_REG(0), .RD_MODE(0)) dut0 (
    .sys_clk(clk), .sys_rst(sys_rst), .clr_req(clr_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data0), .rd_valid(rd_valid0), .init_busy(busy0)
  );

  sdp_ram_ctrl #(.DATA_W(32), .ADDR_W(8), .OUT_REG(1), .RD_MODE(1)) dut1 (
    .sys_clk(clk), .sys_rst(sys_rst), .clr_req(clr_req),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .init_busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o,
                                        input logic [31:0] n,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rd_valid0) begin
      if (q0.size() == 0) chk("dut0 unexpected rd_valid", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("dut0 rd_data", rd_data0, e.d);
        chk("dut0 latency", cyc, e.c);
      end
    end
    if (rd_valid1) begin
      if (q1.size() == 0) chk("dut1 unexpected rd_valid", 32'd1, 32'd0);
      else begin
        e = q1.pop_front();
        chk("dut1 rd_data", rd_data1, e.d);
        chk("dut1 latency", cyc, e.c);
      end
    end
  end

  // One cycle of stimulus; eff=0 means the DUT is busy and must ignore it.
  task automatic op(input bit we, input logic [7:0] wa, input logic [31:0] wd,
                    input logic [3:0] be, input bit re, input logic [7:0] ra,
                    input bit clr, input bit eff);
    logic [31:0] old_w;
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    rd_en = re; rd_addr = ra; clr_req = clr;
    if (eff) begin
      if (re) begin
        old_w = m_mem[ra];
        q0.push_back('{old_w, cyc + 1});
        q1.push_back('{(we && wa == ra) ? merge(old_w, wd, be) : old_w,
                       cyc + 2});
      end
      if (we) m_mem[wa] = merge(m_mem[wa], wd, be);
      if (clr) for (int i = 0; i < 256; i++) m_mem[i] = '0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) op(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic wait_idle(input string name, input int start, input int exp);
    int t0 = -1;
    int t1 = -1;
    for (int k = 0; k < 2000 && (t0 < 0 || t1 < 0); k++) begin
      if (t0 < 0 && !busy0) t0 = cyc;
      if (t1 < 0 && !busy1) t1 = cyc;
      if (t0 < 0 || t1 < 0) @(negedge clk);
    end
    chk({name, " dut0 busy cycles"}, t0 - start, exp);
    chk({name, " dut1 busy cycles"}, t1 - start, exp);
  endtask

  task automatic hold_reset(input int n);
    @(negedge clk);
    sys_rst = 1'b1;
    wr_en = 0; rd_en = 0; clr_req = 0;
    q0.delete(); q1.delete();
    repeat (n) begin
      @(negedge clk);
      chk("busy0 in reset", busy0, 1);
      chk("busy1 in reset", busy1, 1);
      chk("valid0 in reset", rd_valid0, 0);
      chk("valid1 in reset", rd_valid1, 0);
    end
    sys_rst = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
  endtask

  task automatic read_all();
    for (int a = 0; a < 256; a++) op(0, 0, 0, 0, 1, a[7:0], 0, 1);
    idle(4);
  endtask

  initial begin
    int s;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;
    hold_reset(2);
    chk("rd_data0 reset", rd_data0, 0);
    chk("rd_data1 reset", rd_data1, 0);
    s = cyc;
    wait_idle("power-up clear", s, 256);
    idle(1);
    read_all();

    for (int a = 0; a < 256; a++) op(1, a[7:0], a, 4'hF, 0, 0, 0, 1);
    read_all();

    op(1, 8'd5, 32'h11223344, 4'hF, 0, 0, 0, 1);
    op(1, 8'd5, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 1);
    op(1, 8'd6, 32'hDEADBEEF, 4'h0, 1, 8'd5, 0, 1);
    op(0, 0, 0, 0, 1, 8'd6, 0, 1);

    op(1, 8'd7, 32'h10, 4'hF, 0, 0, 0, 1);
    op(1, 8'd7, 32'h20, 4'hF, 1, 8'd7, 0, 1);
    op(0, 0, 0, 0, 1, 8'd7, 0, 1);
    op(1, 8'd7, 32'hAABBCCDD, 4'b0101, 1, 8'd7, 0, 1);
    op(0, 0, 0, 0, 1, 8'd7, 0, 1);
    idle(4);

    op(1, 8'd9, 32'h99, 4'hF, 1, 8'd3, 1, 1);
    s = cyc;
    chk("busy0 before clr edge", busy0, 0);
    for (int k = 0; k < 10; k++) begin
      op(1, 8'(k + 9), 32'hFFFF_0000 | k, 4'hF, 1, 8'(k), 1, 0);
      if (k == 0) begin
        chk("busy0 after clr edge", busy0, 1);
        chk("busy1 after clr edge", busy1, 1);
      end
    end
    idle(1);
    wait_idle("clr_req clear", s, 257);
    read_all();

    for (int a = 0; a < 256; a++) op(1, a[7:0], a + 1, 4'hF, 0, 0, 0, 1);
    hold_reset(1);
    s = cyc;
    repeat (100) @(negedge clk);
    hold_reset(2);
    s = cyc;
    wait_idle("restarted clear", s, 256);
    read_all();

    idle(4);
    chk("dut0 missing rd_valid", q0.size(), 0);
    chk("dut1 missing rd_valid", q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
